// File: rtl/noc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : noc_pkg
// Description : Shared NoC router definitions: port count, direction index
//               map (4=N, 3=S, 2=E, 1=W, 0=L), default flit width, flit type,
//               wormhole lock state encoding and one-hot/index helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package noc_pkg;

    localparam int NUM_PORTS      = 5;
    localparam int N_IDX          = 4;
    localparam int S_IDX          = 3;
    localparam int E_IDX          = 2;
    localparam int W_IDX          = 1;
    localparam int L_IDX          = 0;
    localparam int DEFAULT_FLIT_W = 32;

    typedef logic [DEFAULT_FLIT_W-1:0] flit_t;

    // Wormhole lock state: IDLE follows the arbiter, LOCKED follows lock_src.
    typedef enum logic [0:0] {
        LOCK_IDLE   = 1'b0,
        LOCK_LOCKED = 1'b1
    } lock_state_t;

    function automatic logic [NUM_PORTS-1:0] idx_to_onehot(input logic [2:0] idx);
        logic [NUM_PORTS-1:0] v_oh;
        v_oh = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (idx == 3'(k)) begin
                v_oh[k] = 1'b1;
            end
        end
        return v_oh;
    endfunction

    // Caller guarantees at most one bit is set.
    function automatic logic [2:0] onehot_to_idx(input logic [NUM_PORTS-1:0] oh);
        logic [2:0] v_idx;
        v_idx = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (oh[k]) begin
                v_idx = 3'(k);
            end
        end
        return v_idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/noc_onehot_mux.sv
`default_nettype none
// ============================================================================
// Module      : noc_onehot_mux
// Description : 5:1 one-hot AND-OR multiplexer for flit payload plus tail.
//               i_sel  - one-hot select (all-zero yields zero outputs)
//               i_flit - packed per-input flits, input k at [k*FLIT_W +: FLIT_W]
//               i_tail - per-input tail flags
//               o_flit / o_tail - selected flit and tail
// Revision    : 1.0 - initial release
// ============================================================================
module noc_onehot_mux
    import noc_pkg::*;
#(
    parameter int FLIT_W = DEFAULT_FLIT_W
) (
    input  logic [NUM_PORTS-1:0]        i_sel,
    input  logic [NUM_PORTS*FLIT_W-1:0] i_flit,
    input  logic [NUM_PORTS-1:0]        i_tail,
    output logic [FLIT_W-1:0]           o_flit,
    output logic                        o_tail
);

    always_comb begin
        o_flit = '0;
        o_tail = 1'b0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            o_flit = o_flit | (i_flit[k*FLIT_W +: FLIT_W] & {FLIT_W{i_sel[k]}});
            o_tail = o_tail | (i_tail[k] & i_sel[k]);
        end
    end

endmodule
`default_nettype wire

// File: rtl/noc_output_port.sv
`default_nettype none
// ============================================================================
// Module      : noc_output_port
// Description : NoC router output channel. Takes the arbiter's one-hot turn
//               vector, pops the granted input buffer and registers the flit
//               onto the downstream valid/ready link. Sticky err_o flags a
//               non-one-hot turn (with traffic present) or a turn back to the
//               own port. Optional wormhole lock: NOC_WORMHOLE_EN.
// Ports       : clk, rst (sync, active-low)
//               turn_i, in_valid_i, in_flit_i, in_tail_i, in_pop_o (upstream)
//               out_valid_o, out_flit_o, out_tail_o, out_ready_i (downstream)
//               err_o (sticky protocol error)
// Revision    : 1.0 - initial release
// ============================================================================
module noc_output_port
    import noc_pkg::*;
#(
    parameter int FLIT_W  = DEFAULT_FLIT_W,
    parameter int PORT_ID = N_IDX
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_PORTS-1:0]        turn_i,
    input  logic [NUM_PORTS-1:0]        in_valid_i,
    input  logic [NUM_PORTS*FLIT_W-1:0] in_flit_i,
    input  logic [NUM_PORTS-1:0]        in_tail_i,
    output logic [NUM_PORTS-1:0]        in_pop_o,
    output logic                        out_valid_o,
    output logic [FLIT_W-1:0]           out_flit_o,
    output logic                        out_tail_o,
    input  logic                        out_ready_i,
    output logic                        err_o
);

    localparam logic [NUM_PORTS-1:0] c_OWN_MASK = {{(NUM_PORTS-1){1'b0}}, 1'b1} << PORT_ID;

    logic                 w_accept;
    logic                 w_turn_bad;
    logic                 w_own_bad;
    logic                 w_chk_en;
    logic                 w_err_cond;
    logic                 w_load;
    logic [NUM_PORTS-1:0] w_cand;
    logic [FLIT_W-1:0]    w_mux_flit;
    logic                 w_mux_tail;

    logic                 r_valid;
    logic [FLIT_W-1:0]    r_flit;
    logic                 r_tail;
    logic                 r_err;

    // Register can take a new flit when empty or when its flit leaves this cycle.
    assign w_accept   = !r_valid || out_ready_i;
    assign w_turn_bad = !$onehot(turn_i) && (|in_valid_i);
    assign w_own_bad  = turn_i[PORT_ID];

`ifdef NOC_WORMHOLE_EN
    lock_state_t r_state;
    logic [2:0]  r_lock_src;

    // While locked the arbiter is ignored, so its turn vector is not checked.
    assign w_chk_en = (r_state == LOCK_IDLE);
    assign w_cand   = w_chk_en ? (turn_i & in_valid_i & ~c_OWN_MASK)
                               : (idx_to_onehot(r_lock_src) & in_valid_i);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= LOCK_IDLE;
            r_lock_src <= '0;
        end else if (w_load) begin
            case (r_state)
                LOCK_IDLE: begin
                    // Single-flit packets (head is tail) never lock.
                    if (!w_mux_tail) begin
                        r_state    <= LOCK_LOCKED;
                        r_lock_src <= onehot_to_idx(w_cand);
                    end
                end
                LOCK_LOCKED: begin
                    if (w_mux_tail) begin
                        r_state <= LOCK_IDLE;
                    end
                end
                default: r_state <= LOCK_IDLE;
            endcase
        end
    end
`else
    assign w_chk_en = 1'b1;
    assign w_cand   = turn_i & in_valid_i & ~c_OWN_MASK;
`endif

    assign w_err_cond = w_chk_en && (w_turn_bad || w_own_bad);

    // An erroneous turn suppresses the pop even if the masked vector happens
    // to hold a single bit.
    assign w_load   = w_accept && $onehot(w_cand) && !w_err_cond;
    assign in_pop_o = (rst && w_load) ? w_cand : '0;

    noc_onehot_mux #(
        .FLIT_W (FLIT_W)
    ) u_mux (
        .i_sel  (w_cand),
        .i_flit (in_flit_i),
        .i_tail (in_tail_i),
        .o_flit (w_mux_flit),
        .o_tail (w_mux_tail)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_valid <= 1'b0;
            r_flit  <= '0;
            r_tail  <= 1'b0;
        end else if (w_load) begin
            r_valid <= 1'b1;
            r_flit  <= w_mux_flit;
            r_tail  <= w_mux_tail;
        end else if (out_ready_i) begin
            r_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_err <= 1'b0;
        end else if (w_err_cond) begin
            r_err <= 1'b1;
        end
    end

    assign out_valid_o = r_valid;
    assign out_flit_o  = r_flit;
    assign out_tail_o  = r_tail;
    assign err_o       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_noc_output_port.sv
`default_nettype none
// ============================================================================
// Module      : tb_noc_output_port
// Description : Self-checking bench for noc_output_port (PORT_ID = N).
//               Expected flits are queued when a pop is expected and checked
//               when the downstream handshake completes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_noc_output_port;

    localparam int FLIT_W = 32;

    logic              clk;
    logic              rst;
    logic [4:0]        turn_i;
    logic [4:0]        in_valid_i;
    logic [5*FLIT_W-1:0] in_flit_i;
    logic [4:0]        in_tail_i;
    logic [4:0]        in_pop_o;
    logic              out_valid_o;
    logic [FLIT_W-1:0] out_flit_o;
    logic              out_tail_o;
    logic              out_ready_i;
    logic              err_o;

    logic [FLIT_W-1:0] flit_tab [5];
    logic [FLIT_W:0]   sb_q [$];
    logic [4:0]        c_tails;
    int                tests;
    int                fails;

    assign in_flit_i = {flit_tab[4], flit_tab[3], flit_tab[2], flit_tab[1], flit_tab[0]};

    noc_output_port #(
        .FLIT_W  (FLIT_W),
        .PORT_ID (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .turn_i      (turn_i),
        .in_valid_i  (in_valid_i),
        .in_flit_i   (in_flit_i),
        .in_tail_i   (in_tail_i),
        .in_pop_o    (in_pop_o),
        .out_valid_o (out_valid_o),
        .out_flit_o  (out_flit_o),
        .out_tail_o  (out_tail_o),
        .out_ready_i (out_ready_i),
        .err_o       (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at negedge, check combinational pop and the
    // downstream handshake just before the posedge, then advance.
    task automatic cycle(input string tag, input logic [4:0] turn, input logic [4:0] valid,
                         input logic ready, input int src);
        logic [FLIT_W:0] exp_e;
        logic [4:0]      exp_pop;
        turn_i      = turn;
        in_valid_i  = valid;
        out_ready_i = ready;
        #1;
        chk({tag, "_valid"}, out_valid_o, (sb_q.size() != 0));
        if (out_valid_o && ready && sb_q.size() > 0) begin
            exp_e = sb_q.pop_front();
            chk({tag, "_flit"}, out_flit_o, exp_e[FLIT_W-1:0]);
            chk({tag, "_tail"}, out_tail_o, exp_e[FLIT_W]);
        end
        exp_pop = (src >= 0) ? 5'(1 << src) : 5'b0;
        chk({tag, "_pop"}, in_pop_o, exp_pop);
        if (src >= 0) sb_q.push_back({in_tail_i[src], flit_tab[src]});
        @(negedge clk);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b0;
        #1;
        chk({tag, "_rst_pop"}, in_pop_o, 5'b0);
        @(negedge clk);
        chk({tag, "_rst_valid"}, out_valid_o, 1'b0);
        chk({tag, "_rst_flit"}, out_flit_o, 32'h0);
        chk({tag, "_rst_tail"}, out_tail_o, 1'b0);
        chk({tag, "_rst_err"}, err_o, 1'b0);
        sb_q.delete();
        rst = 1'b1;
    endtask

    initial begin
        tests = 0;
        fails = 0;
`ifdef NOC_WORMHOLE_EN
        c_tails = 5'b11111;
`else
        c_tails = 5'b01101;
`endif
        flit_tab[4] = 32'hDEAD_0004;
        flit_tab[3] = 32'hA5A5_0001;
        flit_tab[2] = 32'h0BAD_0002;
        flit_tab[1] = 32'hC0DE_0003;
        flit_tab[0] = 32'h5A5A_0000;
        in_tail_i   = c_tails;
        rst         = 1'b0;
        turn_i      = 5'b01000;
        in_valid_i  = 5'b01000;
        out_ready_i = 1'b1;
        @(negedge clk);
        do_reset("init");

        // Basic forward from S.
        cycle("basic", 5'b01000, 5'b01000, 1'b1, 3);
        chk("basic_next_valid", out_valid_o, 1'b1);
        chk("basic_next_flit", out_flit_o, 32'hA5A5_0001);
        cycle("basic_drain", 5'b00000, 5'b00000, 1'b1, -1);

        // Backpressure: S flit held for 3 cycles while E waits.
        flit_tab[3] = 32'hA5A5_0011;
        cycle("bp_load", 5'b01000, 5'b01000, 1'b1, 3);
        flit_tab[3] = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            cycle("bp_hold", 5'b00100, 5'b00100, 1'b0, -1);
            chk("bp_hold_flit", out_flit_o, 32'hA5A5_0011);
        end
        cycle("bp_release", 5'b00100, 5'b00100, 1'b1, 2);
        chk("bp_nobubble_valid", out_valid_o, 1'b1);
        chk("bp_nobubble_flit", out_flit_o, 32'h0BAD_0002);
        cycle("bp_drain", 5'b00000, 5'b00000, 1'b1, -1);
        flit_tab[3] = 32'hA5A5_0001;

        // Rotating turns, one flit per cycle in order S, E, W, L.
        cycle("rot_s", 5'b01000, 5'b11111, 1'b1, 3);
        cycle("rot_e", 5'b00100, 5'b11111, 1'b1, 2);
        cycle("rot_w", 5'b00010, 5'b11111, 1'b1, 1);
        cycle("rot_l", 5'b00001, 5'b11111, 1'b1, 0);
        cycle("rot_drain", 5'b00000, 5'b00000, 1'b1, -1);
        cycle("rot_idle", 5'b00000, 5'b00000, 1'b1, -1);

        // Own-port turn, then a two-hot turn; err_o is sticky.
        chk("err_pre", err_o, 1'b0);
        cycle("own", 5'b10000, 5'b11111, 1'b1, -1);
        chk("own_err", err_o, 1'b1);
        cycle("twohot", 5'b00110, 5'b11111, 1'b1, -1);
        chk("twohot_err", err_o, 1'b1);
        do_reset("err_clr");

        // Zero turn with traffic present is also an error.
        cycle("zeroturn", 5'b00000, 5'b00001, 1'b1, -1);
        chk("zeroturn_err", err_o, 1'b1);
        do_reset("zero_clr");

`ifdef NOC_WORMHOLE_EN
        // 3-flit packet from E while the turn rotates.
        in_tail_i = 5'b00000;
        cycle("wh_head", 5'b00100, 5'b11111, 1'b1, 2);
        cycle("wh_body", 5'b01000, 5'b11111, 1'b1, 2);
        in_tail_i = 5'b00100;
        cycle("wh_tail", 5'b00010, 5'b11111, 1'b1, 2);
        in_tail_i = c_tails;
        cycle("wh_after", 5'b01000, 5'b11111, 1'b1, 3);
        cycle("wh_drain", 5'b00000, 5'b00000, 1'b1, -1);
        chk("wh_err", err_o, 1'b0);
`endif

        // Reset in the middle of a (possibly locked) packet.
        in_tail_i = 5'b00000;
        cycle("mid_load", 5'b00100, 5'b11111, 1'b1, 2);
        cycle("mid_hold", 5'b00100, 5'b11111, 1'b0, -1);
        do_reset("mid");
        cycle("mid_after", 5'b01000, 5'b11111, 1'b1, 3);
        in_tail_i = c_tails;
        cycle("mid_tail", 5'b01000, 5'b11111, 1'b1, 3);
        cycle("mid_drain", 5'b00000, 5'b00000, 1'b1, -1);
        cycle("mid_idle", 5'b00000, 5'b00000, 1'b1, -1);
        chk("final_err", err_o, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
